// File: rtl/param_control_unit.sv
// Microcontroller sequencer: variable-length fetch over a req/ready bus, decode and one-cycle execute,
// plus memory load/store, jumps, conditional branches and a HALT/resume debug state.
module param_control_unit #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic [3:0]        CCR_Result,
  input  logic              resume,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_addr_src,
  output logic              IR_Load,
  output logic              PC_Inc,
  output logic              PC_Load,
  output logic              PC_Src,
  output logic [REG_AW-1:0] reg_read_addr_A,
  output logic [REG_AW-1:0] reg_read_addr_B,
  output logic [REG_AW-1:0] reg_write_addr,
  output logic              reg_write_enable,
  output logic [1:0]        wb_sel,
  output logic [3:0]        ALU_Sel,
  output logic              ALU_A_PC,
  output logic              ALU_B_Sel,
  output logic              CCR_Load,
  output logic [DATA_W-1:0] immediate_out,
  output logic [DATA_W-1:0] address_out,
  output logic              halted,
  output logic              illegal_op
);

  typedef enum logic [2:0] {
    S_FETCH_OP,
    S_FETCH_OPND,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_opcode;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic [1:0]        r_cnt;
  logic              r_idx;
  logic              w_last_opnd;
  logic              w_taken;
  logic              w_unused_ok;

  function automatic logic [1:0] opnd_count(input logic [7:0] op);
    case (op)
      8'hA0, 8'hA1, 8'h20, 8'h21, 8'h22, 8'h23,
      8'h24, 8'h25, 8'h26, 8'h30:                         opnd_count = 2'd1;
      8'h80, 8'h81, 8'h82, 8'h90, 8'h91, 8'h92,
      8'h93, 8'h94:                                       opnd_count = 2'd2;
      default:                                            opnd_count = 2'd0;
    endcase
  endfunction

  // Flag V is not used by any branch condition
  assign w_unused_ok = CCR_Result[1];
  assign w_last_opnd = r_idx || (r_cnt == 2'd1);

  always_comb begin
    w_taken = 1'b0;
    case (r_opcode)
      8'h20: w_taken = 1'b1;
      8'h21: w_taken = CCR_Result[0];
      8'h22: w_taken = !CCR_Result[0];
      8'h23: w_taken = !CCR_Result[2];
      8'h24: w_taken = CCR_Result[2];
      8'h25: w_taken = CCR_Result[3];
      8'h26: w_taken = !CCR_Result[3];
      default: w_taken = 1'b0;
    endcase
  end

  assign immediate_out = (r_opcode == 8'h80) ? r_op2 : r_op1;
  assign address_out   = ((r_opcode == 8'h81) || (r_opcode == 8'h82)) ? r_op2 : r_op1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_FETCH_OP;
      r_opcode <= 8'h00;
      r_op1    <= '0;
      r_op2    <= '0;
      r_cnt    <= 2'd0;
      r_idx    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH_OP && mem_ready) begin
        r_opcode <= mem_rdata[7:0];
        r_cnt    <= opnd_count(mem_rdata[7:0]);
        r_idx    <= 1'b0;
      end
      if (r_state == S_FETCH_OPND && mem_ready) begin
        if (!r_idx) r_op1 <= mem_rdata;
        else        r_op2 <= mem_rdata;
        r_idx <= 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is held so a pending bus request drops at once
  always_comb begin
    w_next           = r_state;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr_src     = 1'b0;
    IR_Load          = 1'b0;
    PC_Inc           = 1'b0;
    PC_Load          = 1'b0;
    PC_Src           = 1'b0;
    reg_read_addr_A  = '0;
    reg_read_addr_B  = '0;
    reg_write_addr   = '0;
    reg_write_enable = 1'b0;
    wb_sel           = 2'b00;
    ALU_Sel          = 4'd0;
    ALU_A_PC         = 1'b0;
    ALU_B_Sel        = 1'b0;
    CCR_Load         = 1'b0;
    halted           = 1'b0;
    illegal_op       = 1'b0;
    if (reset) begin
      case (r_state)
        S_FETCH_OP: begin
          mem_req = 1'b1;
          IR_Load = mem_ready;
          PC_Inc  = mem_ready;
          if (mem_ready)
            w_next = (opnd_count(mem_rdata[7:0]) == 2'd0) ? S_EXEC : S_FETCH_OPND;
        end
        S_FETCH_OPND: begin
          mem_req = 1'b1;
          PC_Inc  = mem_ready;
          if (mem_ready && w_last_opnd) w_next = S_EXEC;
        end
        S_EXEC: begin
          w_next = S_FETCH_OP;
          case (r_opcode)
            8'h90, 8'h91, 8'h92, 8'h93, 8'h94: begin
              case (r_opcode)
                8'h90:   ALU_Sel = 4'd0;
                8'h91:   ALU_Sel = 4'd1;
                8'h92:   ALU_Sel = 4'd4;
                8'h93:   ALU_Sel = 4'd5;
                default: ALU_Sel = 4'd6;
              endcase
              reg_read_addr_A  = r_op1[REG_AW-1:0];
              reg_read_addr_B  = r_op2[REG_AW-1:0];
              reg_write_addr   = r_op1[REG_AW-1:0];
              reg_write_enable = 1'b1;
              CCR_Load         = 1'b1;
            end
            8'hA0, 8'hA1: begin
              ALU_Sel          = (r_opcode == 8'hA0) ? 4'd7 : 4'd8;
              reg_read_addr_A  = r_op1[REG_AW-1:0];
              reg_write_addr   = r_op1[REG_AW-1:0];
              reg_write_enable = 1'b1;
              CCR_Load         = 1'b1;
            end
            8'h80: begin
              reg_write_addr   = r_op1[REG_AW-1:0];
              reg_write_enable = 1'b1;
              wb_sel           = 2'b01;
            end
            8'h81, 8'h82: w_next = S_MEM;
            8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26: begin
              ALU_A_PC  = 1'b1;
              ALU_B_Sel = 1'b1;
              PC_Load   = w_taken;
            end
            8'h30: begin
              PC_Load = 1'b1;
              PC_Src  = 1'b1;
            end
            8'h00: ;
            8'hFF: w_next = S_HALT;
            default: illegal_op = 1'b1;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_src = 1'b1;
          if (r_opcode == 8'h82) begin
            mem_we          = 1'b1;
            reg_read_addr_A = r_op1[REG_AW-1:0];
          end else begin
            reg_write_enable = mem_ready;
            reg_write_addr   = r_op1[REG_AW-1:0];
            wb_sel           = 2'b10;
          end
          if (mem_ready) w_next = S_FETCH_OP;
        end
        S_HALT: begin
          halted = 1'b1;
          if (resume) w_next = S_FETCH_OP;
        end
        default: w_next = S_FETCH_OP;
      endcase
    end
  end

endmodule
